// File: rtl/io_bus_pkg.sv
// Shared definitions for the I/O bus bridge: address region codes,
// the bridge state encoding and default bus widths.
package io_bus_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int ADDR_W_DEF = 16;

  // Region codes taken from the top nibble of the processor address
  localparam logic [3:0] REG_RAM   = 4'h0;
  localparam logic [3:0] REG_LED   = 4'h1;
  localparam logic [3:0] REG_SW    = 4'h2;
  localparam logic [3:0] REG_TIMER = 4'h3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_RAM_WAIT,
    ST_RESP
  } state_t;

endpackage

// File: rtl/io_timer.sv
// Free-running tick timer: a prescaler divides the clock, and each prescaler
// wrap bumps a wrapping counter. A load overrides any tick in the same cycle
// and restarts the prescaler so the loaded value is held for a full period.
module io_timer #(
  parameter int PRESCALE = 50000,
  parameter int CNT_W    = 16
) (
  input  logic             i_clock,
  input  logic             i_resetn,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  output logic [CNT_W-1:0] o_count
);

  localparam int PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);

  logic [PRE_W-1:0] r_pre;
  logic [CNT_W-1:0] r_count;
  logic             w_tick;

  assign w_tick  = (r_pre == PRE_LAST);
  assign o_count = r_count;

  // Prescaler and counter; a load wins over a coincident tick
  always_ff @(posedge i_clock or negedge i_resetn) begin
    if (!i_resetn) begin
      r_pre   <= '0;
      r_count <= '0;
    end else if (i_load) begin
      r_pre   <= '0;
      r_count <= i_load_val;
    end else begin
      r_pre <= w_tick ? '0 : r_pre + 1'b1;
      if (w_tick) begin
        r_count <= r_count + 1'b1;
      end
    end
  end

endmodule

// File: rtl/io_bus_bridge.sv
// Bridge between the processor memory port and data RAM plus board I/O.
// One request at a time is latched, decoded by address region and completed
// with a single-cycle ack; busy covers acceptance through the ack cycle.
module io_bus_bridge
  import io_bus_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int RAM_AW   = 8,
  parameter int LED_W    = 10,
  parameter int PRESCALE = 50000
) (
  input  logic              i_clock,
  input  logic              i_resetn,
  input  logic              i_req,
  input  logic              i_wr,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] o_rdata,
  output logic              o_ack,
  output logic              o_busy,
  output logic [RAM_AW-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_data,
  output logic              o_mem_wren,
  input  logic [DATA_W-1:0] i_mem_q,
  input  logic [LED_W-1:0]  i_sw,
  output logic [LED_W-1:0]  o_ledr,
  output logic              o_bus_err
);

  localparam int TIMER_W = 16;

  state_t              r_state;
  state_t              w_next;
  logic                r_wr;
  logic [3:0]          r_region;
  logic [RAM_AW-1:0]   r_ram_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic [DATA_W-1:0]   r_rdata;
  logic                r_ack;
  logic                r_busy;
  logic [LED_W-1:0]    r_ledr;
  logic                r_bus_err;
  logic [LED_W-1:0]    r_sw_meta;
  logic [LED_W-1:0]    r_sw_sync;
  logic [3:0]          w_region;
  logic                w_accept;
  logic                w_mem_wren;
  logic                w_timer_load;
  logic [TIMER_W-1:0]  w_count;
  logic                w_unused_addr;

  // Address bits between the RAM window and the region nibble are don't-care
  assign w_unused_addr = ^i_addr[ADDR_W-5:RAM_AW];
  assign w_region      = i_addr[ADDR_W-1 -: 4];
  // The busy term keeps a held req from being re-accepted during the ack cycle
  assign w_accept      = (r_state == ST_IDLE) && i_req && !r_busy;

  assign o_rdata    = r_rdata;
  assign o_ack      = r_ack;
  assign o_busy     = r_busy;
  assign o_mem_addr = r_ram_addr;
  assign o_mem_data = r_wdata;
  assign o_mem_wren = w_mem_wren;
  assign o_ledr     = r_ledr;
  assign o_bus_err  = r_bus_err;

  // State register
  always_ff @(posedge i_clock or negedge i_resetn) begin
    if (!i_resetn) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state decode plus the single-cycle RAM write and timer load strobes
  always_comb begin
    w_next       = r_state;
    w_mem_wren   = 1'b0;
    w_timer_load = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_next = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        w_mem_wren   = r_wr && (r_region == REG_RAM);
        w_timer_load = r_wr && (r_region == REG_TIMER);
        if (!r_wr && (r_region == REG_RAM)) begin
          w_next = ST_RAM_WAIT;
        end else begin
          w_next = ST_RESP;
        end
      end
      ST_RAM_WAIT: w_next = ST_RESP;
      ST_RESP:     w_next = ST_IDLE;
      default:     w_next = ST_IDLE;
    endcase
  end

  // Capture the request so the core may change its bus after acceptance
  always_ff @(posedge i_clock or negedge i_resetn) begin
    if (!i_resetn) begin
      r_wr       <= 1'b0;
      r_region   <= REG_RAM;
      r_ram_addr <= '0;
      r_wdata    <= '0;
    end else if (w_accept) begin
      r_wr       <= i_wr;
      r_region   <= w_region;
      r_ram_addr <= i_addr[RAM_AW-1:0];
      r_wdata    <= i_wdata;
    end
  end

  // Registered ack leaving RESP; busy drops on the edge after the ack cycle
  always_ff @(posedge i_clock or negedge i_resetn) begin
    if (!i_resetn) begin
      r_ack  <= 1'b0;
      r_busy <= 1'b0;
    end else begin
      r_ack <= (r_state == ST_RESP);
      if (w_accept) begin
        r_busy <= 1'b1;
      end else if (r_ack) begin
        r_busy <= 1'b0;
      end
    end
  end

  // Two-flop synchroniser for the asynchronous board switches
  always_ff @(posedge i_clock or negedge i_resetn) begin
    if (!i_resetn) begin
      r_sw_meta <= '0;
      r_sw_sync <= '0;
    end else begin
      r_sw_meta <= i_sw;
      r_sw_sync <= r_sw_meta;
    end
  end

  // Peripheral writes, read data return and the sticky unmapped-access flag
  always_ff @(posedge i_clock or negedge i_resetn) begin
    if (!i_resetn) begin
      r_rdata   <= '0;
      r_ledr    <= '0;
      r_bus_err <= 1'b0;
    end else if (r_state == ST_ACCESS) begin
      case (r_region)
        REG_RAM: begin
        end
        REG_LED: begin
          if (r_wr) begin
            r_ledr <= r_wdata[LED_W-1:0];
          end else begin
            r_rdata <= DATA_W'(r_ledr);
          end
        end
        REG_SW: begin
          if (!r_wr) begin
            r_rdata <= DATA_W'(r_sw_sync);
          end
        end
        REG_TIMER: begin
          if (!r_wr) begin
            r_rdata <= DATA_W'(w_count);
          end
        end
        default: begin
          r_bus_err <= 1'b1;
          if (!r_wr) begin
            r_rdata <= '0;
          end
        end
      endcase
    end else if (r_state == ST_RAM_WAIT) begin
      r_rdata <= i_mem_q;
    end
  end

  io_timer #(
    .PRESCALE (PRESCALE),
    .CNT_W    (TIMER_W)
  ) u_timer (
    .i_clock    (i_clock),
    .i_resetn   (i_resetn),
    .i_load     (w_timer_load),
    .i_load_val (r_wdata[TIMER_W-1:0]),
    .o_count    (w_count)
  );

endmodule

// File: tb/tb_io_bus_bridge.sv
// Scoreboard bench for io_bus_bridge: stimulus pushes the expected response,
// a monitor pops and compares on every ack. A behavioural RAM sits on the
// memory port.
module tb_io_bus_bridge;

  localparam int DATA_W      = 16;
  localparam int ADDR_W      = 16;
  localparam int RAM_AW      = 8;
  localparam int LED_W       = 10;
  localparam int PRESCALE    = 4;
  localparam int ACK_TIMEOUT = 20;

  typedef struct {
    logic [15:0] expRdata;
    int          latency;
    int          issueCycle;
    bit          isRamWrite;
    logic [7:0]  memAddr;
    logic [15:0] memData;
  } expItem_t;

  logic              clock   = 1'b0;
  logic              resetn  = 1'b0;
  logic              req     = 1'b0;
  logic              wr      = 1'b0;
  logic [ADDR_W-1:0] addr    = '0;
  logic [DATA_W-1:0] wdata   = '0;
  logic [LED_W-1:0]  sw      = '0;
  logic [DATA_W-1:0] rdata;
  logic              ack;
  logic              busy;
  logic [RAM_AW-1:0] memAddr;
  logic [DATA_W-1:0] memData;
  logic              memWren;
  logic [DATA_W-1:0] memQ = '0;
  logic [LED_W-1:0]  ledr;
  logic              busErr;

  logic [15:0] ramMem [0:255];
  expItem_t    expQ[$];
  string       nameQ[$];
  int          checks     = 0;
  int          errors     = 0;
  int          cycleCount = 0;
  int          wrenCount  = 0;
  logic [7:0]  wrenAddr   = '0;
  logic [15:0] wrenData   = '0;
  logic [15:0] modelRdata = '0;
  logic [9:0]  swDrive    = '0;

  io_bus_bridge #(
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .RAM_AW   (RAM_AW),
    .LED_W    (LED_W),
    .PRESCALE (PRESCALE)
  ) dut (
    .i_clock    (clock),
    .i_resetn   (resetn),
    .i_req      (req),
    .i_wr       (wr),
    .i_addr     (addr),
    .i_wdata    (wdata),
    .o_rdata    (rdata),
    .o_ack      (ack),
    .o_busy     (busy),
    .o_mem_addr (memAddr),
    .o_mem_data (memData),
    .o_mem_wren (memWren),
    .i_mem_q    (memQ),
    .i_sw       (sw),
    .o_ledr     (ledr),
    .o_bus_err  (busErr)
  );

  // Free-running clock
  always #5 clock = ~clock;

  // Behavioural synchronous RAM with one-cycle read latency
  always @(posedge clock) begin
    if (memWren) begin
      ramMem[memAddr] <= memData;
    end
    memQ <= ramMem[memAddr];
  end

  // Edge counter used to measure request-to-ack latency
  initial forever begin
    @(posedge clock);
    cycleCount++;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic pushExpect(input string name, input bit isWrite, input logic [15:0] a,
                            input logic [15:0] d, input logic [15:0] expRd, input int latency);
    expItem_t item;
    item.issueCycle = cycleCount + 1;
    item.latency    = latency;
    item.isRamWrite = isWrite && (a[15:12] == 4'h0);
    item.memAddr    = a[7:0];
    item.memData    = d;
    if (isWrite) begin
      item.expRdata = modelRdata;
    end else begin
      item.expRdata = expRd;
      modelRdata    = expRd;
    end
    expQ.push_back(item);
    nameQ.push_back(name);
  endtask

  task automatic applyStimulus(input string name, input bit isWrite, input logic [15:0] a,
                               input logic [15:0] d, input logic [15:0] expRd, input int latency);
    bit seen;
    @(negedge clock);
    sw    = swDrive;
    req   = 1'b1;
    wr    = isWrite;
    addr  = a;
    wdata = d;
    pushExpect(name, isWrite, a, d, expRd, latency);
    seen = 1'b0;
    for (int i = 0; i < ACK_TIMEOUT && !seen; i++) begin
      @(negedge clock);
      if (ack) seen = 1'b1;
    end
    req = 1'b0;
    if (!seen) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s_ack_timeout: got no ack, expected ack within %0d cycles", name, ACK_TIMEOUT);
      if (expQ.size() > 0) begin
        void'(expQ.pop_front());
        void'(nameQ.pop_front());
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clock);
  endtask

  // Monitor: tallies RAM write strobes and scores every ack against the queue
  initial forever begin
    expItem_t item;
    string    nm;
    @(negedge clock);
    if (memWren) begin
      wrenCount++;
      wrenAddr = memAddr;
      wrenData = memData;
    end
    if (ack) begin
      if (expQ.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_ack: got ack with rdata 0x%0h, expected no ack", rdata);
      end else begin
        item = expQ.pop_front();
        nm   = nameQ.pop_front();
        checkOutput({nm, "_rdata"}, 32'(rdata), 32'(item.expRdata));
        checkOutput({nm, "_latency"}, 32'(cycleCount - item.issueCycle), 32'(item.latency));
        checkOutput({nm, "_busy"}, 32'(busy), 32'd1);
        checkOutput({nm, "_wren_pulses"}, 32'(wrenCount), item.isRamWrite ? 32'd1 : 32'd0);
        if (item.isRamWrite) begin
          checkOutput({nm, "_mem_addr"}, 32'(wrenAddr), 32'(item.memAddr));
          checkOutput({nm, "_mem_data"}, 32'(wrenData), 32'(item.memData));
        end
      end
      wrenCount = 0;
    end
  end

  // Hard stop in case the sequence stalls outside a bounded wait
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no completion, expected finish before 200000 time units");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed test sequence
  initial begin
    for (int i = 0; i < 256; i++) ramMem[i] = 16'h0000;

    idle(2);
    checkOutput("reset_ack", 32'(ack), 32'd0);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_rdata", 32'(rdata), 32'd0);
    checkOutput("reset_mem_wren", 32'(memWren), 32'd0);
    checkOutput("reset_mem_addr", 32'(memAddr), 32'd0);
    checkOutput("reset_mem_data", 32'(memData), 32'd0);
    checkOutput("reset_ledr", 32'(ledr), 32'd0);
    checkOutput("reset_bus_err", 32'(busErr), 32'd0);
    resetn = 1'b1;
    idle(2);

    $display("[TB] RAM write/read");
    applyStimulus("sd_0005", 1'b1, 16'h0005, 16'hBEEF, 16'h0000, 2);
    applyStimulus("ld_0005", 1'b0, 16'h0005, 16'h0000, 16'hBEEF, 3);
    applyStimulus("sd_00a0", 1'b1, 16'h00A0, 16'h1234, 16'h0000, 2);
    applyStimulus("ld_00a0", 1'b0, 16'h00A0, 16'h0000, 16'h1234, 3);
    applyStimulus("ld_0f05_alias", 1'b0, 16'h0F05, 16'h0000, 16'hBEEF, 3);

    $display("[TB] LED register");
    applyStimulus("led_wr_3ff", 1'b1, 16'h1000, 16'h03FF, 16'h0000, 2);
    checkOutput("ledr_after_3ff", 32'(ledr), 32'h3FF);
    applyStimulus("led_rd_3ff", 1'b0, 16'h1000, 16'h0000, 16'h03FF, 2);
    applyStimulus("led_wr_fc00", 1'b1, 16'h1000, 16'hFC00, 16'h0000, 2);
    checkOutput("ledr_after_fc00", 32'(ledr), 32'h000);
    applyStimulus("led_rd_000", 1'b0, 16'h1000, 16'h0000, 16'h0000, 2);

    $display("[TB] Switch synchroniser");
    swDrive = 10'h2A5;
    @(negedge clock);
    sw = swDrive;
    idle(2);
    applyStimulus("sw_rd_2a5", 1'b0, 16'h2000, 16'h0000, 16'h02A5, 2);
    swDrive = 10'h3C3;
    applyStimulus("sw_rd_stale", 1'b0, 16'h2000, 16'h0000, 16'h02A5, 2);
    applyStimulus("sw_rd_3c3", 1'b0, 16'h2000, 16'h0000, 16'h03C3, 2);

    // Load lands at edge L; ticks at L+4 and L+8; the read samples at L+10
    $display("[TB] Timer");
    applyStimulus("tmr_wr_fffe", 1'b1, 16'h3000, 16'hFFFE, 16'h0000, 2);
    idle(6);
    applyStimulus("tmr_rd_wrap", 1'b0, 16'h3000, 16'h0000, 16'h0000, 2);
    // Back-to-back writes: the second load lands exactly on a prescaler wrap
    applyStimulus("tmr_wr_1000", 1'b1, 16'h3000, 16'h1000, 16'h0000, 2);
    applyStimulus("tmr_wr_2222_on_tick", 1'b1, 16'h3000, 16'h2222, 16'h0000, 2);
    applyStimulus("tmr_rd_2222", 1'b0, 16'h3000, 16'h0000, 16'h2222, 2);
    applyStimulus("tmr_rd_2223", 1'b0, 16'h3000, 16'h0000, 16'h2223, 2);

    // Unmapped read, with a stray write request presented while busy
    $display("[TB] Unmapped access and busy guard");
    @(negedge clock);
    req   = 1'b1;
    wr    = 1'b0;
    addr  = 16'h5000;
    wdata = 16'h0000;
    pushExpect("unmapped_rd", 1'b0, 16'h5000, 16'h0000, 16'h0000, 2);
    @(negedge clock);
    req = 1'b0;
    @(negedge clock);
    req   = 1'b1;
    wr    = 1'b1;
    addr  = 16'h1000;
    wdata = 16'h02AA;
    @(negedge clock);
    @(negedge clock);
    req = 1'b0;
    idle(4);
    checkOutput("bus_err_set", 32'(busErr), 32'd1);
    checkOutput("busy_write_ignored", 32'(ledr), 32'h000);
    applyStimulus("led_wr_155", 1'b1, 16'h1000, 16'h0155, 16'h0000, 2);
    checkOutput("ledr_after_155", 32'(ledr), 32'h155);
    checkOutput("bus_err_sticky", 32'(busErr), 32'd1);

    // Reset while a RAM read sits in RAM_WAIT abandons it without an ack
    $display("[TB] Reset mid-transaction");
    @(negedge clock);
    req  = 1'b1;
    wr   = 1'b0;
    addr = 16'h0005;
    @(posedge clock);
    #1;
    @(posedge clock);
    #1;
    checkOutput("pre_reset_busy", 32'(busy), 32'd1);
    resetn = 1'b0;
    #1;
    checkOutput("mid_reset_busy", 32'(busy), 32'd0);
    checkOutput("mid_reset_ack", 32'(ack), 32'd0);
    checkOutput("mid_reset_ledr", 32'(ledr), 32'd0);
    checkOutput("mid_reset_bus_err", 32'(busErr), 32'd0);
    checkOutput("mid_reset_rdata", 32'(rdata), 32'd0);
    @(negedge clock);
    req = 1'b0;
    @(negedge clock);
    resetn = 1'b1;
    modelRdata = 16'h0000;
    idle(6);
    checkOutput("post_reset_busy", 32'(busy), 32'd0);
    applyStimulus("post_reset_ld", 1'b0, 16'h0005, 16'h0000, 16'hBEEF, 3);

    idle(3);
    checkOutput("queue_drained", 32'(expQ.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
